// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide controller: 32-cycle shift-add multiply and restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply for the MUL family.
module muldiv_sequencer #(
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [BITS-1:0] rs1_data,
    input  logic [BITS-1:0] rs2_data,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] result
);

    // ALUCtrl codes shared with alu_control_def.v
    localparam logic [4:0] ALUCTRL_MUL    = 5'd16;
    localparam logic [4:0] ALUCTRL_MULH   = 5'd17;
    localparam logic [4:0] ALUCTRL_MULHSU = 5'd18;
    localparam logic [4:0] ALUCTRL_MULHU  = 5'd19;
    localparam logic [4:0] ALUCTRL_DIV    = 5'd20;
    localparam logic [4:0] ALUCTRL_DIVU   = 5'd21;
    localparam logic [4:0] ALUCTRL_REM    = 5'd22;
    localparam logic [4:0] ALUCTRL_REMU   = 5'd23;

    localparam logic [BITS-1:0] INT_MIN    = {1'b1, {(BITS-1){1'b0}}};
    localparam logic [4:0]      LAST_COUNT = 5'(BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [4:0]        count;
    logic [2*BITS-1:0] acc;
    logic [BITS-1:0]   opa;
    logic              neg_a;
    logic              neg_b;
    logic              is_mul;
    logic              sel_hi;

    logic              op_valid;
    logic              op_mul;
    logic              op_high;
    logic              op_rem;
    logic              sgn1;
    logic              sgn2;
    logic              neg1;
    logic              neg2;
    logic [BITS-1:0]   mag1;
    logic [BITS-1:0]   mag2;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic              launch;
    logic [BITS-1:0]   special_result;

    logic [BITS:0]     mul_sum;
    logic [BITS:0]     div_shift;
    logic              div_ge;
    logic [BITS-1:0]   div_sub;
    logic [2*BITS-1:0] acc_next;
    logic [2*BITS-1:0] prod;
    logic [BITS-1:0]   quo;
    logic [BITS-1:0]   rem;
    logic [BITS-1:0]   fix_result;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*BITS-1:0] fast_prod;
`endif

    always_comb begin
        op_valid = 1'b1;
        op_mul   = 1'b0;
        op_high  = 1'b0;
        op_rem   = 1'b0;
        sgn1     = 1'b0;
        sgn2     = 1'b0;
        case (op)
            ALUCTRL_MUL: begin
                op_mul = 1'b1;
                sgn1   = 1'b1;
                sgn2   = 1'b1;
            end
            ALUCTRL_MULH: begin
                op_mul  = 1'b1;
                op_high = 1'b1;
                sgn1    = 1'b1;
                sgn2    = 1'b1;
            end
            ALUCTRL_MULHSU: begin
                op_mul  = 1'b1;
                op_high = 1'b1;
                sgn1    = 1'b1;
            end
            ALUCTRL_MULHU: begin
                op_mul  = 1'b1;
                op_high = 1'b1;
            end
            ALUCTRL_DIV: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            ALUCTRL_DIVU: begin
            end
            ALUCTRL_REM: begin
                op_rem = 1'b1;
                sgn1   = 1'b1;
                sgn2   = 1'b1;
            end
            ALUCTRL_REMU: begin
                op_rem = 1'b1;
            end
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        neg1     = sgn1 & rs1_data[BITS-1];
        neg2     = sgn2 & rs2_data[BITS-1];
        mag1     = neg1 ? -rs1_data : rs1_data;
        mag2     = neg2 ? -rs2_data : rs2_data;
        div_zero = op_valid & ~op_mul & (rs2_data == '0);
        div_ovf  = op_valid & ~op_mul & sgn1 & (rs1_data == INT_MIN) & (rs2_data == '1);
        special  = div_zero | div_ovf;
`ifdef MULDIV_FAST_MUL_EN
        special  = special | (op_valid & op_mul);
`endif
        launch   = start & op_valid & ((state == IDLE) || (state == DONE));
        stall    = (state == CALC) || (state == FIX) || (launch & ~special);
    end

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = op_rem ? rs1_data : '1;
        end else if (div_ovf) begin
            special_result = op_rem ? '0 : INT_MIN;
        end
`ifdef MULDIV_FAST_MUL_EN
        // Sign-extending both operands to 2*BITS makes the low 2*BITS of the product exact.
        fast_prod = {{BITS{neg1}}, rs1_data} * {{BITS{sgn2 & rs2_data[BITS-1]}}, rs2_data};
        if (op_mul) begin
            special_result = op_high ? fast_prod[2*BITS-1:BITS] : fast_prod[BITS-1:0];
        end
`endif
    end

    // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*BITS-1:BITS]} + ({1'b0, opa} & {(BITS+1){acc[0]}});
        div_shift = {acc[2*BITS-1:BITS], acc[BITS-1]};
        div_ge    = div_shift >= {1'b0, opa};
        div_sub   = div_shift[BITS-1:0] - opa;
        if (is_mul) begin
            acc_next = {mul_sum, acc[BITS-1:1]};
        end else if (div_ge) begin
            acc_next = {div_sub, acc[BITS-2:0], 1'b1};
        end else begin
            acc_next = {div_shift[BITS-1:0], acc[BITS-2:0], 1'b0};
        end
    end

    always_comb begin
        prod = neg_a ? -acc : acc;
        quo  = neg_a ? -acc[BITS-1:0] : acc[BITS-1:0];
        rem  = neg_b ? -acc[2*BITS-1:BITS] : acc[2*BITS-1:BITS];
        if (is_mul) begin
            fix_result = sel_hi ? prod[2*BITS-1:BITS] : prod[BITS-1:0];
        end else begin
            fix_result = sel_hi ? rem : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            opa    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            is_mul <= 1'b0;
            sel_hi <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (kill) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (launch) begin
                        if (special) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_result;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            count  <= '0;
                            acc    <= {{BITS{1'b0}}, op_mul ? mag2 : mag1};
                            opa    <= op_mul ? mag1 : mag2;
                            neg_a  <= neg1 ^ neg2;
                            neg_b  <= neg1;
                            is_mul <= op_mul;
                            sel_hi <= op_high | op_rem;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_result;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of model results, latency and handshake checks.
module tb_muldiv_sequencer;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    muldiv_sequencer #(.BITS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1_data (rs1),
        .rs2_data (rs2),
        .kill     (kill),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic [31:0]        r;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        r   = '0;
        case (o)
            OP_MUL:    begin p = sa * sb; r = p[31:0];  end
            OP_MULH:   begin p = sa * sb; r = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
            OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
            OP_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            OP_DIVU: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            OP_REM: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            OP_REMU: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic start_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        if (push) exp_q.push_back(model(o, a, b));
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    // Drives one op, scrambles inputs after the start cycle, then scores latency and result.
    task automatic do_op(input string name, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat);
        int          t0;
        bit          seen;
        logic [31:0] exp;
        @(posedge clk); #1;
        start_op(o, a, b, 1'b1);
        t0 = cyc;
        #1;
        total++;
        if (stall !== (lat != 1)) $display("FAIL %s_stall: got %b want %b", name, stall, lat != 1);
        else passed++;
        @(posedge clk); #1;
        start = 1'b0;
        op    = OP_ADD;
        rs1   = $urandom;
        rs2   = $urandom;
        wait_done(lat + 10, seen);
        total++;
        if (!seen) $display("FAIL %s_timeout: no done within %0d cycles", name, lat + 10);
        else if (cyc - t0 != lat) $display("FAIL %s_latency: got %0d want %0d", name, cyc - t0, lat);
        else passed++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (seen) begin
                total++;
                if (result !== exp) $display("FAIL %s_result: got %h want %h", name, result, exp);
                else passed++;
                last_exp = exp;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = OP_ADD; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
        rst_n = 1'b1;
        last_exp = '0;
    endtask

    task automatic test_mul_timing();
        logic exp_busy;
        logic exp_stall;
        logic exp_done;
        logic [31:0] exp;
        @(posedge clk); #1;
        start_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            exp_busy  = (k >= 1) && (k <= 33);
            exp_stall = (k <= 33);
            exp_done  = (k == 34);
            total++; if (busy !== exp_busy) $display("FAIL mul_busy_t%0d: got %b want %b", k, busy, exp_busy); else passed++;
            total++; if (stall !== exp_stall) $display("FAIL mul_stall_t%0d: got %b want %b", k, stall, exp_stall); else passed++;
            total++; if (done !== exp_done) $display("FAIL mul_done_t%0d: got %b want %b", k, done, exp_done); else passed++;
            if (k == 0) begin
                @(posedge clk); #1;
                start = 1'b0;
                rs1   = $urandom;
                rs2   = $urandom;
            end
        end
        exp = exp_q.pop_front();
        total++;
        if (result !== exp) $display("FAIL mul_timing_result: got %h want %h", result, exp);
        else passed++;
        last_exp = exp;
    endtask

    task automatic test_mul_variants();
        do_op("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 34);
        do_op("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        do_op("mulhsu_neg", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         34);
        do_op("mul_big",    OP_MUL,    32'h1234_5678, 32'h9ABC_DEF0, 34);
        do_op("mulhsu_big", OP_MULHSU, 32'h8000_0001, 32'hFFFF_FFFF, 34);
    endtask

    task automatic test_div_special();
        do_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1);
        do_op("divu_zero", OP_DIVU, 32'd5,         32'd0,         1);
        do_op("remu_zero", OP_REMU, 32'd5,         32'd0,         1);
        do_op("div_zero",  OP_DIV,  32'hFFFF_FF00, 32'd0,         1);
        do_op("rem_zero",  OP_REM,  32'hFFFF_FF00, 32'd0,         1);
        do_op("divu_big",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    endtask

    task automatic test_div();
        do_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         34);
        do_op("rem_neg",   OP_REM,  32'hFFFF_FFF9, 32'd2,         34);
        do_op("remu_100",  OP_REMU, 32'd100,       32'd7,         34);
        do_op("div_negd",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 34);
        do_op("rem_negd",  OP_REM,  32'd7,         32'hFFFF_FFFE, 34);
        do_op("divu_max",  OP_DIVU, 32'hFFFF_FFFF, 32'd1,         34);
    endtask

    task automatic test_invalid_op();
        @(posedge clk); #1;
        start_op(OP_ADD, 32'd1, 32'd2, 1'b0);
        #1;
        total++; if (stall !== 1'b0) $display("FAIL invalid_stall: got %b want 0", stall); else passed++;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++; if ({busy, done} !== 2'b00) $display("FAIL invalid_busy_done: got %b want 00", {busy, done}); else passed++;
        end
        total++; if (result !== last_exp) $display("FAIL invalid_result: got %h want %h", result, last_exp); else passed++;
    endtask

    task automatic test_kill();
        bit seen_done = 1'b0;
        @(posedge clk); #1;
        start_op(OP_DIV, 32'd1000, 32'd7, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        @(posedge clk); #1;
        kill = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) $display("FAIL kill_busy_before: got %b want 1", busy); else passed++;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        if (done === 1'b1) seen_done = 1'b1;
        total++; if (busy !== 1'b0) $display("FAIL kill_busy: got %b want 0", busy); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL kill_stall: got %b want 0", stall); else passed++;
        total++; if (seen_done !== 1'b0) $display("FAIL kill_done: got %b want 0", seen_done); else passed++;
        total++; if (result !== last_exp) $display("FAIL kill_result: got %h want %h", result, last_exp); else passed++;
        do_op("divu_after_kill", OP_DIVU, 32'd9, 32'd3, 34);
    endtask

    task automatic test_back_to_back();
        int          t0;
        bit          seen;
        logic [31:0] exp;
        @(posedge clk); #1;
        start_op(OP_MUL, 32'd5, 32'd6, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            wait_done(50, seen);
            total++;
            if (!seen) $display("FAIL b2b%0d_timeout: no done within 50 cycles", n);
            else if (cyc - t0 != (n == 2 ? 1 : 34)) $display("FAIL b2b%0d_latency: got %0d want %0d", n, cyc - t0, n == 2 ? 1 : 34);
            else passed++;
            exp = exp_q.pop_front();
            total++;
            if (result !== exp) $display("FAIL b2b%0d_result: got %h want %h", n, result, exp);
            else passed++;
            last_exp = exp;
            if (n < 2) begin
                // Issued mid-DONE cycle so it is sampled on the edge that leaves DONE.
                if (n == 0) start_op(OP_MUL, 32'd3, 32'd4, 1'b1);
                else        start_op(OP_DIVU, 32'd5, 32'd0, 1'b1);
                t0 = cyc;
                #1;
                total++;
                if (stall !== (n == 0)) $display("FAIL b2b%0d_stall: got %b want %b", n, stall, n == 0);
                else passed++;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        @(posedge clk); #1;
        start_op(OP_MUL, 32'd123, 32'd456, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL arst_done: got %b want 0", done); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL arst_stall: got %b want 0", stall); else passed++;
        total++; if (result !== 32'h0) $display("FAIL arst_result: got %h want 0", result); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        wait_done(40, seen);
        total++; if (seen !== 1'b0) $display("FAIL arst_no_done: got %b want 0", seen); else passed++;
    endtask

    task automatic test_random();
        logic [4:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            o = 5'(OP_MUL + $urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            lat = 34;
            if ((o >= OP_DIV) && ((b == 0) || ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                lat = 1;
            do_op($sformatf("rand%0d", i), o, a, b, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mul_variants();
        test_div_special();
        test_div();
        test_invalid_op();
        test_kill();
        test_back_to_back();
        test_random();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
